// File: rtl/tb_test_supervisor.sv
// End-of-test supervisor: tracks per-hart pass/fail, an exit-code write, a cycle timeout and
// a retirement stall watchdog, then drains a fixed number of cycles before raising sticky done.
module tb_test_supervisor #(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned CYCLE_W        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned STALL_LIMIT    = 10000,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter logic [31:0] EXIT_ADDR      = 32'h2000_0004
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_enable_i,
  input  logic [NUM_HARTS-1:0] pass_i,
  input  logic [NUM_HARTS-1:0] fail_i,
  input  logic [NUM_HARTS-1:0] retire_i,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 done_o,
  output logic                 passed_o,
  output logic                 failed_o,
  output logic                 timeout_o,
  output logic                 stall_o,
  output logic [31:0]          exit_code_o,
  output logic [CYCLE_W-1:0]   cycle_count_o
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CYCLE_W-1:0] TIMEOUT_LIM = CYCLE_W'(TIMEOUT_CYCLES);
  localparam logic [CYCLE_W-1:0] STALL_LIM   = CYCLE_W'(STALL_LIMIT);
  localparam logic [DRAIN_W-1:0] DRAIN_LIM   = DRAIN_W'(DRAIN_CYCLES);

  localparam logic [31:0] CODE_TIMEOUT = 32'hFFFF_FFFE;
  localparam logic [31:0] CODE_STALL   = 32'hFFFF_FFFD;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [CYCLE_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [NUM_HARTS-1:0] mask_q, mask_d;
  logic                 passed_q, passed_d;
  logic                 failed_q, failed_d;
  logic                 timeout_q, timeout_d;
  logic                 stall_q, stall_d;
  logic [31:0]          exit_code_q, exit_code_d;

  logic                 exit_wr;
  logic                 fail_any;
  logic [31:0]          fail_idx;
  logic                 timeout_hit;
  logic                 stall_hit;
  logic                 pass_hit;
  logic                 verdict;
  logic [CYCLE_W-1:0]   cycle_inc;
  logic [CYCLE_W-1:0]   stall_inc;

  assign exit_wr   = data_req_i & data_we_i & (data_addr_i == EXIT_ADDR);
  assign fail_any  = |fail_i;
  assign cycle_inc = (&cycle_q) ? cycle_q : cycle_q + CYCLE_W'(1);
  assign stall_inc = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CYCLE_W'(1);

  // Lowest-indexed failing hart wins; scan downwards so the last hit is the lowest.
  always_comb begin
    fail_idx = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (fail_i[h]) fail_idx = 32'(h);
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    stall_cnt_d = stall_cnt_q;
    drain_d     = drain_q;
    mask_d      = mask_q;
    passed_d    = passed_q;
    failed_d    = failed_q;
    timeout_d   = timeout_q;
    stall_d     = stall_q;
    exit_code_d = exit_code_q;
    timeout_hit = 1'b0;
    stall_hit   = 1'b0;
    pass_hit    = 1'b0;
    verdict     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cycle_d     = '0;
        stall_cnt_d = '0;
        drain_d     = '0;
        mask_d      = '0;
        if (fetch_enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        cycle_d     = cycle_inc;
        stall_cnt_d = (|retire_i) ? '0 : stall_inc;
        mask_d      = mask_q | pass_i;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_d >= TIMEOUT_LIM);
        stall_hit   = (STALL_LIMIT != 0) && (stall_cnt_d >= STALL_LIM);
        pass_hit    = (exit_wr && (data_wdata_i == '0)) || (&mask_d);
        verdict     = 1'b1;
        if (fail_any || (exit_wr && (data_wdata_i != '0))) begin
          failed_d    = 1'b1;
          exit_code_d = fail_any ? fail_idx + 32'd1 : data_wdata_i;
        end else if (timeout_hit) begin
          failed_d    = 1'b1;
          timeout_d   = 1'b1;
          exit_code_d = CODE_TIMEOUT;
        end else if (stall_hit) begin
          failed_d    = 1'b1;
          stall_d     = 1'b1;
          exit_code_d = CODE_STALL;
        end else if (pass_hit) begin
          passed_d    = 1'b1;
          exit_code_d = '0;
        end else begin
          verdict = 1'b0;
        end
        if (verdict) state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        cycle_d = cycle_inc;
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_d == DRAIN_LIM) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cycle_q     <= '0;
      stall_cnt_q <= '0;
      drain_q     <= '0;
      mask_q      <= '0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stall_q     <= 1'b0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      stall_cnt_q <= stall_cnt_d;
      drain_q     <= drain_d;
      mask_q      <= mask_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
      exit_code_q <= exit_code_d;
    end
  end

  assign done_o        = (state_q == ST_DONE);
  assign passed_o      = passed_q;
  assign failed_o      = failed_q;
  assign timeout_o     = timeout_q;
  assign stall_o       = stall_q;
  assign exit_code_o   = exit_code_q;
  assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_tb_test_supervisor.sv
// Directed bench for tb_test_supervisor: five instances with different parameters share one
// stimulus bus, each started by its own fetch enable so only one is running at a time.
module tb_tb_test_supervisor;

  localparam logic [31:0] EXIT_ADDR = 32'h2000_0004;
  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe [N];
  logic [3:0]  pass_v;
  logic [3:0]  fail_v;
  logic [3:0]  retire_v;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        done_w    [N];
  logic        passed_w  [N];
  logic        failed_w  [N];
  logic        timeout_w [N];
  logic        stall_w   [N];
  logic [31:0] code_w    [N];
  logic [31:0] count_w   [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: four harts, 2: timeout only, 3: timeout 50 + stall 20, 4: no drain
  tb_test_supervisor #(.NUM_HARTS(1)) u_def (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe[0]),
    .pass_i(pass_v[0:0]), .fail_i(fail_v[0:0]), .retire_i(retire_v[0:0]),
    .data_req_i(req), .data_we_i(we), .data_addr_i(addr), .data_wdata_i(wdata),
    .done_o(done_w[0]), .passed_o(passed_w[0]), .failed_o(failed_w[0]),
    .timeout_o(timeout_w[0]), .stall_o(stall_w[0]), .exit_code_o(code_w[0]),
    .cycle_count_o(count_w[0]));

  tb_test_supervisor #(.NUM_HARTS(4)) u_four (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe[1]),
    .pass_i(pass_v), .fail_i(fail_v), .retire_i(retire_v),
    .data_req_i(req), .data_we_i(we), .data_addr_i(addr), .data_wdata_i(wdata),
    .done_o(done_w[1]), .passed_o(passed_w[1]), .failed_o(failed_w[1]),
    .timeout_o(timeout_w[1]), .stall_o(stall_w[1]), .exit_code_o(code_w[1]),
    .cycle_count_o(count_w[1]));

  tb_test_supervisor #(.NUM_HARTS(1), .TIMEOUT_CYCLES(50), .STALL_LIMIT(0)) u_tmo (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe[2]),
    .pass_i(pass_v[0:0]), .fail_i(fail_v[0:0]), .retire_i(retire_v[0:0]),
    .data_req_i(req), .data_we_i(we), .data_addr_i(addr), .data_wdata_i(wdata),
    .done_o(done_w[2]), .passed_o(passed_w[2]), .failed_o(failed_w[2]),
    .timeout_o(timeout_w[2]), .stall_o(stall_w[2]), .exit_code_o(code_w[2]),
    .cycle_count_o(count_w[2]));

  tb_test_supervisor #(.NUM_HARTS(1), .TIMEOUT_CYCLES(50), .STALL_LIMIT(20)) u_stl (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe[3]),
    .pass_i(pass_v[0:0]), .fail_i(fail_v[0:0]), .retire_i(retire_v[0:0]),
    .data_req_i(req), .data_we_i(we), .data_addr_i(addr), .data_wdata_i(wdata),
    .done_o(done_w[3]), .passed_o(passed_w[3]), .failed_o(failed_w[3]),
    .timeout_o(timeout_w[3]), .stall_o(stall_w[3]), .exit_code_o(code_w[3]),
    .cycle_count_o(count_w[3]));

  tb_test_supervisor #(.NUM_HARTS(1), .DRAIN_CYCLES(0)) u_nodrain (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe[4]),
    .pass_i(pass_v[0:0]), .fail_i(fail_v[0:0]), .retire_i(retire_v[0:0]),
    .data_req_i(req), .data_we_i(we), .data_addr_i(addr), .data_wdata_i(wdata),
    .done_o(done_w[4]), .passed_o(passed_w[4]), .failed_o(failed_w[4]),
    .timeout_o(timeout_w[4]), .stall_o(stall_w[4]), .exit_code_o(code_w[4]),
    .cycle_count_o(count_w[4]));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-24s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic exit_write(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick(1);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic start(input int i);
    fe[i] = 1'b1;
    tick(1);
    fe[i] = 1'b0;
  endtask

  task automatic retire_pulse();
    retire_v = 4'b0001;
    tick(1);
    retire_v = '0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) fe[i] = 1'b0;
    pass_v = '0; fail_v = '0; retire_v = '0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick(3);
    check("rst_done", done_w[0], 0);
    check("rst_passed", passed_w[0], 0);
    check("rst_failed", failed_w[0], 0);
    check("rst_code", code_w[0], 0);
    check("rst_count", count_w[0], 0);
    rst = 1'b0;

    // exit 0 after 100 RUN cycles: pass, done 17 edges later, count frozen at 117
    tick(2);
    start(0);
    tick(100);
    check("pass_count_at_write", count_w[0], 100);
    exit_write(EXIT_ADDR, 32'd0);
    check("pass_passed", passed_w[0], 1);
    check("pass_failed", failed_w[0], 0);
    check("pass_code", code_w[0], 0);
    check("pass_done_early", done_w[0], 0);
    tick(15);
    check("pass_done_edge16", done_w[0], 0);
    tick(1);
    check("pass_done_edge17", done_w[0], 1);
    check("pass_count_final", count_w[0], 117);
    tick(5);
    check("pass_count_frozen", count_w[0], 117);

    // nonzero exit code fails; write elsewhere ignored; later exit write in DRAIN ignored
    do_reset();
    start(0);
    tick(10);
    exit_write(EXIT_ADDR + 32'd4, 32'd0);
    check("wrong_addr_passed", passed_w[0], 0);
    exit_write(EXIT_ADDR, 32'h0000_002A);
    check("fail42_failed", failed_w[0], 1);
    check("fail42_passed", passed_w[0], 0);
    check("fail42_code", code_w[0], 42);
    tick(1);
    exit_write(EXIT_ADDR, 32'd0);
    check("fail42_code_kept", code_w[0], 42);
    check("fail42_passed_kept", passed_w[0], 0);

    // asynchronous reset in DRAIN aborts without a verdict, then a fresh run passes
    #1 rst = 1'b1;
    #1;
    check("abort_failed", failed_w[0], 0);
    check("abort_code", code_w[0], 0);
    check("abort_count", count_w[0], 0);
    check("abort_done", done_w[0], 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    start(0);
    tick(20);
    exit_write(EXIT_ADDR, 32'd0);
    tick(16);
    check("rerun_done", done_w[0], 1);
    check("rerun_passed", passed_w[0], 1);
    check("rerun_count", count_w[0], 37);

    // four harts: pass only once hart 3 joins harts 0,2,1
    do_reset();
    start(1);
    pass_v = 4'b0001; tick(1);
    check("mask_h0", passed_w[1], 0);
    pass_v = 4'b0100; tick(1);
    check("mask_h2", passed_w[1], 0);
    pass_v = 4'b0010; tick(1);
    check("mask_h1", passed_w[1], 0);
    pass_v = 4'b1000; tick(1);
    pass_v = '0;
    check("mask_full_passed", passed_w[1], 1);
    check("mask_full_code", code_w[1], 0);

    // fail on hart 2 beats pass on hart 0 in the same cycle
    do_reset();
    start(1);
    tick(3);
    fail_v = 4'b0100; pass_v = 4'b0001;
    tick(1);
    fail_v = '0; pass_v = '0;
    check("fail_h2_failed", failed_w[1], 1);
    check("fail_h2_passed", passed_w[1], 0);
    check("fail_h2_code", code_w[1], 3);

    // timeout after 50 RUN cycles
    do_reset();
    start(2);
    tick(49);
    check("tmo_before", timeout_w[2], 0);
    tick(1);
    check("tmo_timeout", timeout_w[2], 1);
    check("tmo_failed", failed_w[2], 1);
    check("tmo_code", code_w[2], 32'hFFFF_FFFE);
    check("tmo_stall", stall_w[2], 0);

    // stall 20 cycles after the last of two retires (count 40, below timeout)
    do_reset();
    start(3);
    for (int k = 0; k < 2; k++) begin
      tick(9);
      retire_pulse();
    end
    tick(19);
    check("stall_before", stall_w[3], 0);
    tick(1);
    check("stall_stall", stall_w[3], 1);
    check("stall_failed", failed_w[3], 1);
    check("stall_code", code_w[3], 32'hFFFF_FFFD);
    check("stall_timeout", timeout_w[3], 0);

    // last retire at cycle 30: stall and timeout both hit at cycle 50, timeout wins
    do_reset();
    start(3);
    for (int k = 0; k < 3; k++) begin
      tick(9);
      retire_pulse();
    end
    tick(19);
    check("both_before", failed_w[3], 0);
    tick(1);
    check("both_timeout", timeout_w[3], 1);
    check("both_stall", stall_w[3], 0);
    check("both_code", code_w[3], 32'hFFFF_FFFE);

    // no drain: done together with the verdict flags
    do_reset();
    start(4);
    tick(5);
    check("nodrain_done_before", done_w[4], 0);
    exit_write(EXIT_ADDR, 32'd0);
    check("nodrain_passed", passed_w[4], 1);
    check("nodrain_done", done_w[4], 1);
    tick(3);
    check("nodrain_count", count_w[4], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
